button_score_counter: RTL and testbench

BUTTON_SCORE_COUNTER -- requirements
Module: button_score_counter

---
 rtl/button_score_counter.sv | 143 ++++++++++++++
 tb/tb_button_score_counter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/button_score_counter.sv
// Three debounced pushbuttons drive a saturating 8-bit count with press-and-hold
// auto-repeat; step_pulse marks every cycle in which number takes a new value.
module button_score_counter #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int MAX_VALUE       = 255
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_clr,
    output logic [7:0] number,
    output logic       step_pulse,
    output logic       at_max,
    output logic       at_min
);
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REPEAT_PERIOD - 1);
    localparam logic [7:0]       MAX_V    = 8'(MAX_VALUE);

    typedef enum logic [1:0] {IDLE, STEP, DELAY, REPEAT} state_t;

    // Bit 0 = up, bit 1 = down, bit 2 = clear throughout the button path.
    logic [2:0]      w_raw;
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_db;
    logic [DB_W-1:0] r_db_cnt [3];

    state_t           r_state;
    logic             r_dir;
    logic             r_clr_prev;
    logic [TMR_W-1:0] r_timer;
    logic [7:0]       r_number;
    logic             r_step_pulse;

    logic       w_cmd_up;
    logic       w_cmd_dn;
    logic       w_cmd_lost;
    logic       w_clr_rise;
    logic [7:0] w_stepped;

    function automatic logic [7:0] f_step(input logic [7:0] v, input logic up);
        if (up) begin
            return (v >= MAX_V) ? v : v + 8'd1;
        end
        return (v == 8'd0) ? v : v - 8'd1;
    endfunction

    assign w_raw      = {btn_clr, btn_down, btn_up};
    assign w_cmd_up   = r_db[0] & ~r_db[1];
    assign w_cmd_dn   = r_db[1] & ~r_db[0];
    assign w_cmd_lost = r_dir ? ~w_cmd_up : ~w_cmd_dn;
    assign w_clr_rise = r_db[2] & ~r_clr_prev;
    assign w_stepped  = f_step(r_number, r_dir);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_dir        <= 1'b0;
            r_clr_prev   <= 1'b0;
            r_timer      <= '0;
            r_number     <= 8'd0;
            r_step_pulse <= 1'b0;
        end else begin
            r_clr_prev   <= r_db[2];
            r_step_pulse <= 1'b0;
            if (w_clr_rise) begin
                r_number     <= 8'd0;
                r_step_pulse <= (r_number != 8'd0);
                r_state      <= IDLE;
                r_timer      <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if ((w_cmd_up | w_cmd_dn) & ~r_db[2]) begin
                            r_dir   <= w_cmd_up;
                            r_state <= STEP;
                        end
                    end
                    STEP: begin
                        r_number     <= w_stepped;
                        r_step_pulse <= (w_stepped != r_number);
                        r_timer      <= '0;
                        r_state      <= DELAY;
                    end
                    DELAY, REPEAT: begin
                        // A release, reversal or conflict abandons the hold without stepping.
                        if (w_cmd_lost) begin
                            r_state <= IDLE;
                            r_timer <= '0;
                        end else if (r_timer == ((r_state == DELAY) ? DLY_LAST : PER_LAST)) begin
                            r_number     <= w_stepped;
                            r_step_pulse <= (w_stepped != r_number);
                            r_timer      <= '0;
                            r_state      <= REPEAT;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign number     = r_number;
    assign step_pulse = r_step_pulse;
    assign at_max     = (r_number == MAX_V);
    assign at_min     = (r_number == 8'd0);

endmodule

// File: tb/tb_button_score_counter.sv
// Scoreboard bench: an event-level model predicts every cycle's outputs into a
// queue that a negedge monitor drains and compares against the counter.
module tb_button_score_counter;
    localparam int DBC  = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;
    localparam int MAXV = 5;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_clr = 1'b0;
    logic [7:0] number;
    logic       step_pulse;
    logic       at_max;
    logic       at_min;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    typedef struct {
        logic [7:0] num;
        logic       pulse;
        logic       amax;
        logic       amin;
    } exp_t;
    exp_t sbq[$];

    button_score_counter #(
        .DEBOUNCE_CYCLES(DBC),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP),
        .MAX_VALUE(MAXV)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_clr(btn_clr),
        .number(number),
        .step_pulse(step_pulse),
        .at_max(at_max),
        .at_min(at_min)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    // Reference model: buttons seen two edges late; a level flips once the last
    // DBC delayed samples all disagree with it. Hold behaviour is expressed as
    // the age of the hold since its first step.
    int         m_num;
    bit         m_pulse;
    bit [2:0]   m_db;
    bit         m_clrprev;
    int         m_phase;    // 0 idle, 1 step due next edge, 2 holding
    bit         m_dir;
    int         m_age;
    logic [2:0] raw_hist[$];
    logic [2:0] dly_hist[$];

    function automatic int step_of(input int v, input bit up);
        if (up) return (v < MAXV) ? v + 1 : v;
        return (v > 0) ? v - 1 : v;
    endfunction

    always @(posedge CLOCK) begin
        logic [2:0] d;
        bit cu, cd, all_flip;
        int nv;
        if (RESET) begin
            m_num = 0; m_pulse = 0; m_db = '0; m_clrprev = 0;
            m_phase = 0; m_dir = 0; m_age = 0;
            raw_hist = '{3'b000, 3'b000};
            dly_hist.delete();
        end else begin
            cu = m_db[0] && !m_db[1];
            cd = m_db[1] && !m_db[0];
            m_pulse = 0;
            if (m_db[2] && !m_clrprev) begin
                m_pulse = (m_num != 0);
                m_num = 0;
                m_phase = 0;
            end else if (m_phase == 0) begin
                if ((cu || cd) && !m_db[2]) begin
                    m_phase = 1;
                    m_dir = cu;
                end
            end else if (m_phase == 1) begin
                nv = step_of(m_num, m_dir);
                m_pulse = (nv != m_num);
                m_num = nv;
                m_phase = 2;
                m_age = 0;
            end else begin
                if (m_dir ? !cu : !cd) begin
                    m_phase = 0;
                end else begin
                    m_age++;
                    if (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0)) begin
                        nv = step_of(m_num, m_dir);
                        m_pulse = (nv != m_num);
                        m_num = nv;
                    end
                end
            end
            m_clrprev = m_db[2];
            raw_hist.push_back({btn_clr, btn_down, btn_up});
            d = raw_hist.pop_front();
            dly_hist.push_back(d);
            if (dly_hist.size() > DBC) void'(dly_hist.pop_front());
            if (dly_hist.size() == DBC) begin
                for (int b = 0; b < 3; b++) begin
                    all_flip = 1;
                    foreach (dly_hist[i]) if (dly_hist[i][b] == m_db[b]) all_flip = 0;
                    if (all_flip) m_db[b] = !m_db[b];
                end
            end
        end
        sbq.push_back('{8'(m_num), m_pulse, (m_num == MAXV), (m_num == 0)});
    end

    always @(negedge CLOCK) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("number", 32'(number), 32'(e.num));
            chk("step_pulse", 32'(step_pulse), 32'(e.pulse));
            chk("at_max", 32'(at_max), 32'(e.amax));
            chk("at_min", 32'(at_min), 32'(e.amin));
            if (step_pulse === 1'b1) pulses++;
        end
    end

    task automatic clear_press();
        btn_clr = 1'b1; cyc(8); btn_clr = 1'b0; cyc(12);
    endtask

    initial begin
        int p0;
        RESET = 1'b1; cyc(3); RESET = 1'b0; cyc(2);
        chk("reset_num", 32'(number), 0);
        chk("reset_at_min", 32'(at_min), 1);
        chk("reset_at_max", 32'(at_max), 0);

        p0 = pulses; btn_up = 1'b1; cyc(3); btn_up = 1'b0; cyc(20);
        chk("glitch_num", 32'(number), 0);
        chk("glitch_pulses", 32'(pulses - p0), 0);

        p0 = pulses; btn_up = 1'b1; cyc(8); btn_up = 1'b0; cyc(20);
        chk("single_num", 32'(number), 1);
        chk("single_pulses", 32'(pulses - p0), 1);

        clear_press();
        p0 = pulses; btn_up = 1'b1; cyc(40); btn_up = 1'b0; cyc(20);
        chk("hold_num", 32'(number), MAXV);
        chk("hold_at_max", 32'(at_max), 1);
        chk("hold_pulses", 32'(pulses - p0), 5);

        clear_press();
        repeat (3) begin btn_up = 1'b1; cyc(8); btn_up = 1'b0; cyc(20); end
        p0 = pulses; btn_up = 1'b1; btn_down = 1'b1; cyc(30);
        btn_up = 1'b0; btn_down = 1'b0; cyc(20);
        chk("conflict_num", 32'(number), 3);
        chk("conflict_pulses", 32'(pulses - p0), 0);

        clear_press();
        btn_up = 1'b1; cyc(19); btn_clr = 1'b1; cyc(12);
        chk("clr_hold_num", 32'(number), 0);
        btn_clr = 1'b0; cyc(25); btn_up = 1'b0; cyc(20);
        chk("clr_resume_num", 32'(number), MAXV);

        clear_press();
        btn_up = 1'b1; cyc(19);
        RESET = 1'b1; cyc(1); RESET = 1'b0;
        chk("rst_mid_num", 32'(number), 0);
        chk("rst_mid_at_min", 32'(at_min), 1);
        cyc(5);
        chk("rst_redebounce_num", 32'(number), 0);
        cyc(25); btn_up = 1'b0; cyc(20);

        repeat (150) begin
            btn_up   = 1'($urandom_range(0, 1));
            btn_down = 1'($urandom_range(0, 2) == 0);
            btn_clr  = 1'($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) begin
                RESET = 1'b1; cyc(1); RESET = 1'b0;
            end
            cyc($urandom_range(1, 40));
        end
        btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
        cyc(20);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
